// File: rtl/fp_sqrt_sequencer.sv
// ---------------------------------------------------------------------------
// fp_sqrt_sequencer
// Control sequencer for a Newton-Raphson square-root datapath. It steps the
// datapath through load/divide/average/compare micro-operations, counts the
// non-converged iterations and stops either on convergence (ALU sign bit in
// the compare step) or when the iteration limit is reached.
//
// Parameters
//   MAX_ITER      iteration limit before forced termination (1..15)
// Ports
//   clk           rising-edge clock
//   rst           asynchronous, active-high reset
//   start         run request, sampled only in S0
//   ack           result consumed, sampled only in S10
//   Sign          ALU sign bit, sampled only in S8 (1 = converged)
//   current_state state code to the datapath output decoder
//   busy          high while a run is in progress (S1..S9)
//   done          high while the result is presented (S10)
//   timeout       last run stopped on the iteration limit
//   iter_count    completed non-converged iterations of current/last run
// ---------------------------------------------------------------------------
module fp_sqrt_sequencer #(
    parameter int unsigned MAX_ITER = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       ack,
    input  logic       Sign,
    output logic [3:0] current_state,
    output logic       busy,
    output logic       done,
    output logic       timeout,
    output logic [3:0] iter_count
);

    localparam int unsigned STATE_W = 4;
    localparam int unsigned ITER_W  = 4;
    localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);

    typedef enum logic [STATE_W-1:0] {
        S0  = 4'b0000,  // idle
        S1  = 4'b0001,  // load n
        S2  = 4'b0010,  // x = n
        S3  = 4'b0011,  // root = n / x
        S4  = 4'b0100,  // root += x
        S5  = 4'b0101,  // root /= 2
        S6  = 4'b0110,  // temp = root - x
        S7  = 4'b0111,  // temp = |temp|
        S8  = 4'b1000,  // temp -= I, convergence decision
        S9  = 4'b1001,  // x = root
        S10 = 4'b1010   // output / wait for ack
    } state_e;

    // State kept as a plain vector so unused codes 1011..1111 are representable
    // and recover through the default branch.
    logic [STATE_W-1:0] r_state;
    logic [ITER_W-1:0]  r_iter;
    logic               r_timeout;
    logic [ITER_W-1:0]  w_iter_inc;

    assign w_iter_inc = r_iter + ITER_W'(1);

    // Sequencer: state, iteration counter and timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S0;
            r_iter    <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                S0: begin
                    if (start) begin
                        r_state   <= S1;
                        r_iter    <= '0;
                        r_timeout <= 1'b0;
                    end
                end
                S1: r_state <= S2;
                S2: r_state <= S3;
                S3: r_state <= S4;
                S4: r_state <= S5;
                S5: r_state <= S6;
                S6: r_state <= S7;
                S7: r_state <= S8;
                S8: begin
                    if (Sign) begin
                        r_state <= S10;
                    end else begin
                        // Limit compare uses the incremented count so the
                        // counter stops exactly at ITER_LIMIT.
                        r_iter <= w_iter_inc;
                        if (w_iter_inc == ITER_LIMIT) begin
                            r_state   <= S10;
                            r_timeout <= 1'b1;
                        end else begin
                            r_state <= S9;
                        end
                    end
                end
                S9:  r_state <= S3;
                S10: begin
                    if (ack) begin
                        r_state <= S0;
                    end
                end
                default: r_state <= S0;
            endcase
        end
    end

    // Status flags decoded only from the state register, so they always agree
    // with current_state (including unused codes) and have no input path.
    assign current_state = r_state;
    assign busy          = (r_state >= S1) && (r_state <= S9);
    assign done          = (r_state == S10);
    assign timeout       = r_timeout;
    assign iter_count    = r_iter;

endmodule

// File: tb/tb_fp_sqrt_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fp_sqrt_sequencer
// Two sequencer instances (MAX_ITER=15 and MAX_ITER=3). Each run is planned
// as a number of non-converged iterations k and an ack delay d; the expected
// per-cycle state/counter trace is built from those numbers and compared
// every cycle. A result table fixes latency and final status per run, and
// hand-written sequences cover reset, restart and unused state codes.
// ---------------------------------------------------------------------------
module tb_fp_sqrt_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start_v [2];
    logic       ack_v   [2];
    logic       sign_v  [2];
    logic [3:0] st_v    [2];
    logic [3:0] it_v    [2];
    logic       busy_v  [2];
    logic       done_v  [2];
    logic       to_v    [2];

    fp_sqrt_sequencer #(.MAX_ITER(15)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .ack(ack_v[0]), .Sign(sign_v[0]),
        .current_state(st_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .timeout(to_v[0]), .iter_count(it_v[0])
    );

    fp_sqrt_sequencer #(.MAX_ITER(3)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .ack(ack_v[1]), .Sign(sign_v[1]),
        .current_state(st_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .timeout(to_v[1]), .iter_count(it_v[1])
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int u;      // instance
        int k;      // non-converged iterations before Sign=1
        int d;      // cycles of ack=0 in S10
        int lat;    // edges from start until done first seen
        int iter;   // final iter_count
        int to;     // final timeout
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input int u, input int es, input int ei, input int et, input string tag);
        chk($sformatf("%s state", tag), int'(st_v[u]), es);
        chk($sformatf("%s iter", tag), int'(it_v[u]), ei);
        chk($sformatf("%s timeout", tag), int'(to_v[u]), et);
        chk($sformatf("%s busy", tag), int'(busy_v[u]), (es >= 1 && es <= 9) ? 1 : 0);
        chk($sformatf("%s done", tag), int'(done_v[u]), (es == 10) ? 1 : 0);
    endtask

    // Asynchronous reset pulse between clock edges.
    task automatic rst_pulse();
        #2 rst = 1'b1;
        #1 rst = 1'b0;
    endtask

    // One full run from S0 on instance u. The expected trace is a list of
    // (state, iter, timeout) entries, one per clock edge, derived from k, d
    // and the iteration limit; drv holds the Sign/ack value for that cycle.
    task automatic run(input int u, input int k, input int d, input bit chain,
                       output int lat, output int fin_iter, output int fin_to);
        int es[$];
        int ei[$];
        int et[$];
        bit drv[$];
        int mx;
        int it;
        int to;
        bit fin;
        mx  = (u == 0) ? 15 : 3;
        it  = 0;
        to  = 0;
        fin = 1'b0;
        for (int s = 1; s <= 7; s++) begin
            es.push_back(s); ei.push_back(0); et.push_back(0); drv.push_back(1'b0);
        end
        for (int j = 0; !fin; j++) begin
            if (j > 0) begin
                es.push_back(9); ei.push_back(it); et.push_back(0); drv.push_back(1'b0);
                for (int s = 3; s <= 7; s++) begin
                    es.push_back(s); ei.push_back(it); et.push_back(0); drv.push_back(1'b0);
                end
            end
            es.push_back(8); ei.push_back(it); et.push_back(0); drv.push_back(j == k);
            if (j == k) begin
                fin = 1'b1;
            end else begin
                it++;
                if (it == mx) begin
                    to  = 1;
                    fin = 1'b1;
                end
            end
        end
        for (int r = 0; r <= d; r++) begin
            es.push_back(10); ei.push_back(it); et.push_back(to); drv.push_back(r == d);
        end
        es.push_back(0); ei.push_back(it); et.push_back(to); drv.push_back(1'b0);

        lat          = -1;
        start_v[u]   = 1'b1;
        ack_v[u]     = 1'($urandom);
        sign_v[u]    = 1'($urandom);
        for (int idx = 0; idx < es.size(); idx++) begin
            tick();
            check_out(u, es[idx], ei[idx], et[idx], $sformatf("u%0d k%0d c%0d", u, k, idx));
            if (lat < 0 && done_v[u] == 1'b1) lat = idx + 1;
            sign_v[u] = (es[idx] == 8)  ? drv[idx] : 1'($urandom);
            ack_v[u]  = (es[idx] == 10) ? drv[idx] : 1'($urandom);
            if (es[idx] == 0)       start_v[u] = chain;
            else if (es[idx] == 10) start_v[u] = chain ? 1'b1 : 1'($urandom);
            else                    start_v[u] = 1'($urandom);
        end
        ack_v[u]  = 1'b0;
        sign_v[u] = 1'b0;
        fin_iter  = int'(it_v[u]);
        fin_to    = int'(to_v[u]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        int lat, fi, ft;

        tbl[0] = '{u:0, k:0,  d:0, lat:9,   iter:0,  to:0};
        tbl[1] = '{u:0, k:2,  d:3, lat:23,  iter:2,  to:0};
        tbl[2] = '{u:0, k:5,  d:1, lat:44,  iter:5,  to:0};
        tbl[3] = '{u:0, k:14, d:2, lat:107, iter:14, to:0};
        tbl[4] = '{u:0, k:20, d:0, lat:107, iter:15, to:1};
        tbl[5] = '{u:1, k:20, d:5, lat:23,  iter:3,  to:1};
        tbl[6] = '{u:1, k:2,  d:0, lat:23,  iter:2,  to:0};
        tbl[7] = '{u:1, k:1,  d:1, lat:16,  iter:1,  to:0};
        tbl[8] = '{u:1, k:0,  d:0, lat:9,   iter:0,  to:0};
        tbl[9] = '{u:1, k:3,  d:2, lat:23,  iter:3,  to:1};

        rst = 1'b0;
        for (int u = 0; u < 2; u++) begin
            start_v[u] = 1'b0; ack_v[u] = 1'b0; sign_v[u] = 1'b0;
        end

        // Reset forces idle before any clock edge; start held high is ignored.
        #1 rst = 1'b1;
        #2;
        check_out(0, 0, 0, 0, "reset u0");
        check_out(1, 0, 0, 0, "reset u1");
        start_v[0] = 1'b1;
        tick();
        check_out(0, 0, 0, 0, "in reset start");
        tick();
        check_out(0, 0, 0, 0, "in reset start2");
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_out(0, 1, 0, 0, "first edge after release");
        start_v[0] = 1'b0;
        rst_pulse();
        tick();
        check_out(0, 0, 0, 0, "after pulse");

        // Table-driven runs: final status and latency.
        for (int i = 0; i < 10; i++) begin
            run(tbl[i].u, tbl[i].k, tbl[i].d, 1'b0, lat, fi, ft);
            chk($sformatf("tbl%0d latency", i), lat, tbl[i].lat);
            chk($sformatf("tbl%0d final iter", i), fi, tbl[i].iter);
            chk($sformatf("tbl%0d final timeout", i), ft, tbl[i].to);
        end

        // ack and start together in S10 after a timed-out run: S0, then S1
        // with status cleared.
        run(1, 20, 5, 1'b1, lat, fi, ft);
        chk("chain final iter", fi, 3);
        chk("chain final timeout", ft, 1);
        tick();
        check_out(1, 1, 0, 0, "chain restart");
        start_v[1] = 1'b0;
        rst_pulse();
        tick();
        check_out(1, 0, 0, 0, "chain reset");

        // Randomized runs against the trace model.
        for (int n = 0; n < 30; n++) begin
            run(int'($urandom_range(1, 0)), int'($urandom_range(17, 0)),
                int'($urandom_range(4, 0)), 1'b0, lat, fi, ft);
        end

        // Async reset during S5 of the second iteration.
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        for (int c = 0; c < 40 && st_v[0] != 4'd9; c++) begin
            sign_v[0] = 1'b0;
            tick();
        end
        chk("midrun reach S9", int'(st_v[0]), 9);
        chk("midrun iter", int'(it_v[0]), 1);
        for (int c = 0; c < 10 && st_v[0] != 4'd5; c++) begin
            sign_v[0] = 1'($urandom);
            tick();
        end
        chk("midrun reach S5", int'(st_v[0]), 5);
        sign_v[0] = 1'b1;
        #2 rst = 1'b1;
        #1;
        check_out(0, 0, 0, 0, "async rst in S5");
        start_v[0] = 1'b1;
        tick();
        check_out(0, 0, 0, 0, "held rst");
        @(negedge clk);
        rst        = 1'b0;
        start_v[0] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            sign_v[0] = ~sign_v[0];
            ack_v[0]  = ~ack_v[0];
            tick();
            check_out(0, 0, 0, 0, $sformatf("idle after rst %0d", c));
        end
        start_v[0] = 1'b1;
        ack_v[0]   = 1'b0;
        tick();
        check_out(0, 1, 0, 0, "restart after rst");
        start_v[0] = 1'b0;
        rst_pulse();
        tick();

        // Unused state code recovers to S0 on the next edge.
        force u_dut0.r_state = 4'hD;
        #1;
        check_out(0, 13, 0, 0, "unused code");
        #2;
        release u_dut0.r_state;
        tick();
        check_out(0, 0, 0, 0, "unused recover");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fp_sqrt_sequencer.md
FP_SQRT_SEQUENCER -- requirements
Module: fp_sqrt_sequencer

Interface
REQ-001 SHALL have parameter MAX_ITER, default 15, maximum Newton iterations before forced termination (legal range 1..15).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request a square-root run; sampled only in S0.
REQ-005 SHALL have port ack  input  1  consumer has taken the result; sampled only in S10.
REQ-006 SHALL have port Sign  input  1  sign bit of the ALU result; meaningful only in S8 (1 = |root-x| - I < 0, converged).
REQ-007 SHALL have port current_state  output  4  state code driven to the output decoder.
REQ-008 SHALL have port busy  output  1  high in S1..S9.
REQ-009 SHALL have port done  output  1  high in S10.
REQ-010 SHALL have port timeout  output  1  run ended by iteration limit, not convergence.
REQ-011 SHALL have port iter_count  output  4  completed non-converged iterations of current/last run.

Function
REQ-012 SHALL use state codes S0=0000 idle, S1=0001 load n, S2=0010 x=n, S3=0011 root=n/x, S4=0100 root+=x, S5=0101 root/=2, S6=0110 temp=root-x, S7=0111 temp=|temp|, S8=1000 temp-=I, S9=1001 x=root, S10=1010 output.
REQ-013 SHALL register current_state directly; no combinational path from inputs to current_state.
REQ-014 SHALL in S0 go to S1 when start=1, else stay in S0.
REQ-015 SHALL advance unconditionally S1->S2->S3->S4->S5->S6->S7->S8, one cycle each.
REQ-016 SHALL in S8 go to S10 with timeout unchanged (0) when Sign=1.
REQ-017 SHALL in S8 with Sign=0 increment iter_count; if the incremented value equals MAX_ITER go to S10 and set timeout=1, else go to S9.
REQ-018 SHALL go S9->S3 unconditionally.
REQ-019 SHALL hold S10 while ack=0 and go to S0 when ack=1; start is ignored in S10.
REQ-020 SHALL clear iter_count and timeout on the S0->S1 transition; both hold their values through S10 and S0 until then.
REQ-021 SHALL ignore Sign in every state except S8 and ack in every state except S10.
REQ-022 SHALL go to S0 on the next edge from any unused code 1011..1111, with busy=done=0 while there.
REQ-023 SHALL give latency: converged on first iteration = 8 cycles S1..S8 then S10; each extra iteration adds 7 cycles (S9,S3..S8).
REQ-024 SHALL never let iter_count exceed MAX_ITER (no wrap-around).

Reset
REQ-025 SHALL on rst=1 immediately force current_state=S0, iter_count=0, timeout=0, busy=0, done=0, regardless of clk.
REQ-026 SHALL on rst asserted mid-run (any S1..S10) abandon the run; after release wait in S0 for a new start.
REQ-027 SHALL leave S0 no earlier than the first rising edge after rst deasserts with start=1.

Verification
REQ-028 SHALL cover: reset, start=1 one cycle, Sign=1 in first S8 -> states 1,2,3,4,5,6,7,8,10; done=1 on cycle 9; iter_count=0, timeout=0.
REQ-029 SHALL cover: Sign=0 in first two S8, 1 in third -> sequence ...8,9,3..8,9,3..8,10; iter_count=2, timeout=0.
REQ-030 SHALL cover: MAX_ITER=3, Sign held 0 -> S10 after third S8, iter_count=3, timeout=1, S9 visited twice.
REQ-031 SHALL cover: in S10 ack=0 for 5 cycles then ack=1 with start=1 -> stays S10 five cycles, then S0, then S1 next cycle; iter_count/timeout cleared on entering S1.
REQ-032 SHALL cover: rst pulsed asynchronously (between edges) during S5 -> current_state=0000 and busy=0 before next clk edge; Sign toggling outside S8 has no effect.
REQ-033 SHALL cover: current_state forced to 1101 via backdoor -> S0 on next edge, done=busy=0.
